// File: rtl/dma_priority_arbiter.sv
// DMA request front end: DREQ synchronization, polarity/mask, fixed or
// rotating priority arbitration and the HRQ/HLDA hold handshake.
//
// Optional feature macro: DMA_ROTATING_PRIORITY_EN
//   defined   -> command_reg_out_i[4] selects rotating priority
//   undefined -> fixed priority only, channel 0 highest
//
// Ports:
//   clk_i              system clock
//   rst_ni             asynchronous active-low reset
//   dreq_i             raw external requests (asynchronous)
//   command_reg_out_i  [2] disable, [4] rotate, [6] DREQ active-low, [7] DACK active-high
//   mask_reg_out_i     per-channel mask, 1 = masked
//   hlda_i             hold acknowledge from CPU
//   service_done_i     one-cycle end-of-service pulse
//   hrq_o              hold request to CPU
//   dack_o             DMA acknowledge at pin polarity
//   pending_req_o      synchronized, normalized, unmasked requests
//   grant_valid_o      a channel is granted
//   grant_chan_o       granted channel index
module dma_priority_arbiter #(
  parameter int unsigned NCHAN = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NCHAN-1:0] dreq_i,
  input  logic [7:0]       command_reg_out_i,
  input  logic [NCHAN-1:0] mask_reg_out_i,
  input  logic             hlda_i,
  input  logic             service_done_i,
  output logic             hrq_o,
  output logic [NCHAN-1:0] dack_o,
  output logic [NCHAN-1:0] pending_req_o,
  output logic             grant_valid_o,
  output logic [1:0]       grant_chan_o
);

  localparam int unsigned CW = 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD_REQ = 2'd1;
  localparam logic [1:0] ST_GRANT    = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [NCHAN-1:0] sync1_q, sync2_q, pend_q;
  logic [NCHAN-1:0] elig;
  logic [1:0]       state_q, state_d;
  logic             hrq_q, hrq_d;
  logic             gv_q, gv_d;
  logic [CW-1:0]    chan_q, chan_d;
  logic [NCHAN-1:0] dack_q, dack_d;
  logic [CW-1:0]    low_pri;
  logic [CW-1:0]    winner;
  logic [CW-1:0]    idx;
  logic             found;

  // Two-flop synchronizer, then polarity normalization into the pending register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= dreq_i;
      sync2_q <= sync1_q;
      pend_q  <= sync2_q ^ {NCHAN{command_reg_out_i[6]}};
    end
  end

  assign elig = pend_q & ~mask_reg_out_i;

`ifdef DMA_ROTATING_PRIORITY_EN
  logic          rotate_en;
  logic [CW-1:0] low_pri_q, low_pri_d;

  assign rotate_en = command_reg_out_i[4];
  assign low_pri   = rotate_en ? low_pri_q : CW'(NCHAN - 1);

  // Lowest-priority pointer follows the just-serviced channel; an abort leaves it alone
  always_comb begin
    low_pri_d = low_pri_q;
    if (!rotate_en) begin
      low_pri_d = CW'(NCHAN - 1);
    end else if (state_q == ST_GRANT && service_done_i) begin
      low_pri_d = chan_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      low_pri_q <= CW'(NCHAN - 1);
    end else begin
      low_pri_q <= low_pri_d;
    end
  end
`else
  assign low_pri = CW'(NCHAN - 1);
`endif

  // First eligible channel searching upward from low_pri+1 with wrap-around
  always_comb begin
    winner = low_pri;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NCHAN; k++) begin
      idx = low_pri + CW'(k);
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next state and registered outputs, derived from the next state
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig && !command_reg_out_i[2]) state_d = ST_HOLD_REQ;
      end
      ST_HOLD_REQ: begin
        if (elig == '0 || command_reg_out_i[2]) begin
          state_d = ST_IDLE;
        end else if (hlda_i) begin
          state_d = ST_GRANT;
          chan_d  = winner;
        end
      end
      ST_GRANT: begin
        // Completion wins over a simultaneous HLDA fall
        if (service_done_i) begin
          state_d = ST_RELEASE;
        end else if (!hlda_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!hlda_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    hrq_d  = (state_d == ST_HOLD_REQ) || (state_d == ST_GRANT);
    gv_d   = (state_d == ST_GRANT);
    dack_d = gv_d ? (NCHAN'(1) << chan_d) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hrq_q   <= 1'b0;
      gv_q    <= 1'b0;
      chan_q  <= '0;
      dack_q  <= '0;
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      gv_q    <= gv_d;
      chan_q  <= chan_d;
      dack_q  <= dack_d;
    end
  end

  assign hrq_o         = hrq_q;
  assign grant_valid_o = gv_q;
  assign grant_chan_o  = chan_q;
  assign pending_req_o = pend_q;
  // Pin polarity follows the live DACK sense bit
  assign dack_o        = dack_q ^ {NCHAN{~command_reg_out_i[7]}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios with
// literal expectations plus a randomized run against a behavioural model.
module tb_dma_priority_arbiter;

`ifdef DMA_ROTATING_PRIORITY_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_ASK = 1, P_GRANTED = 2, P_RELEASING = 3;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] dreq = 4'h0;
  logic [7:0] cmd = 8'h00;
  logic [3:0] mask = 4'h0;
  logic       hlda = 1'b0;
  logic       sd = 1'b0;
  logic       hrq_o, grant_valid_o;
  logic [3:0] dack_o, pending_req_o;
  logic [1:0] grant_chan_o;

  int  chk_cnt = 0;
  int  pass_cnt = 0;
  bit  chk_en = 1'b0;
  logic [1:0] last_chan;

  // Behavioural model state
  logic [3:0] m_s1, m_s2, m_pend;
  int         m_phase;
  logic [1:0] m_chan;
  int         m_low;

  dma_priority_arbiter #(.NCHAN(4)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .dreq_i            (dreq),
    .command_reg_out_i (cmd),
    .mask_reg_out_i    (mask),
    .hlda_i            (hlda),
    .service_done_i    (sd),
    .hrq_o             (hrq_o),
    .dack_o            (dack_o),
    .pending_req_o     (pending_req_o),
    .grant_valid_o     (grant_valid_o),
    .grant_chan_o      (grant_chan_o)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [1:0] pick(input logic [3:0] e, input int low);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (low + k) % 4;
      if (e[c[1:0]]) return c[1:0];
    end
    return 2'(low);
  endfunction

  function automatic int eff_low();
    return (ROT_EN && cmd[4]) ? m_low : 3;
  endfunction

  function automatic logic [3:0] m_elig();
    return m_pend & ~mask;
  endfunction

  // Model: advance one clock according to the request/hold/grant rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= 4'h0; m_s2 <= 4'h0; m_pend <= 4'h0;
      m_phase <= P_IDLE; m_chan <= 2'd0; m_low <= 3;
    end else begin
      m_s1   <= dreq;
      m_s2   <= m_s1;
      m_pend <= m_s2 ^ {4{cmd[6]}};
      if (!(ROT_EN && cmd[4])) m_low <= 3;
      if (m_phase == P_IDLE) begin
        if (m_elig() != 0 && !cmd[2]) m_phase <= P_ASK;
      end else if (m_phase == P_ASK) begin
        if (m_elig() == 0 || cmd[2]) m_phase <= P_IDLE;
        else if (hlda) begin
          m_phase <= P_GRANTED;
          m_chan  <= pick(m_elig(), eff_low());
        end
      end else if (m_phase == P_GRANTED) begin
        if (sd) begin
          m_phase <= P_RELEASING;
          if (ROT_EN && cmd[4]) m_low <= int'(m_chan);
        end else if (!hlda) m_phase <= P_IDLE;
      end else begin
        if (!hlda) m_phase <= P_IDLE;
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] dk;
      dk = (m_phase == P_GRANTED) ? (4'b0001 << m_chan) : 4'b0000;
      check("model_pending", 8'(pending_req_o), 8'(m_pend));
      check("model_hrq", 8'(hrq_o), 8'(m_phase == P_ASK || m_phase == P_GRANTED));
      check("model_gv", 8'(grant_valid_o), 8'(m_phase == P_GRANTED));
      check("model_dack", 8'(dack_o), 8'(dk ^ {4{~cmd[7]}}));
      if (m_phase == P_GRANTED) check("model_chan", 8'(grant_chan_o), 8'(m_chan));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hrq(input int budget);
    int n = 0;
    while (hrq_o !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("hrq_rise", 8'(hrq_o), 8'd1);
  endtask

  // One full service: request, HLDA after 2 cycles, grant, done pulse, release
  task automatic serve();
    wait_hrq(30);
    step(); step();
    hlda = 1'b1;
    step();
    check("serve_gv", 8'(grant_valid_o), 8'd1);
    last_chan = grant_chan_o;
    sd = 1'b1;
    step();
    sd = 1'b0;
    check("serve_hrq_low", 8'(hrq_o), 8'd0);
    hlda = 1'b0;
  endtask

  task automatic settle(input logic [3:0] idle_dreq);
    dreq = idle_dreq;
    hlda = 1'b0;
    sd = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    logic [1:0] exp_ch;
    // Reset with the clock stopped
    cmd = 8'h04;
    #2 rst_n = 1'b0;
    #3;
    check("rst_hrq", 8'(hrq_o), 8'd0);
    check("rst_dack", 8'(dack_o), 8'h0F);
    check("rst_pending", 8'(pending_req_o), 8'd0);
    check("rst_gv", 8'(grant_valid_o), 8'd0);
    check("rst_chan", 8'(grant_chan_o), 8'd0);
    #40;
    check("rst_hold_hrq", 8'(hrq_o), 8'd0);
    check("rst_hold_dack", 8'(dack_o), 8'h0F);
    check("rst_hold_gv", 8'(grant_valid_o), 8'd0);
    clk_en = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Fixed priority
    cmd = 8'h00; mask = 4'h0; dreq = 4'b1010;
    wait_hrq(20);
    step(); step();
    hlda = 1'b1;
    step();
    check("fix_chan", 8'(grant_chan_o), 8'd1);
    check("fix_dack", 8'(dack_o), 8'b1101);
    sd = 1'b1; step(); sd = 1'b0; hlda = 1'b0;
    serve();
    check("fix_chan_again", 8'(last_chan), 8'd1);
    settle(4'h0);

    // Rotating priority: order 0,1,2,3,0 when the feature is built in
    cmd = 8'h10; dreq = 4'b1111;
    repeat (5) step();
    for (int i = 0; i < 5; i++) begin
      serve();
      exp_ch = ROT_EN ? 2'(i % 4) : 2'd0;
      check("rot_order", 8'(last_chan), 8'(exp_ch));
    end
    settle(4'h0);

    // Masking and disable
    cmd = 8'h00; mask = 4'b0011; dreq = 4'b0011;
    repeat (6) step();
    check("mask_pending", 8'(pending_req_o), 8'b0011);
    check("mask_hrq", 8'(hrq_o), 8'd0);
    mask = 4'h0; cmd = 8'h04; dreq = 4'b1111;
    repeat (6) step();
    check("dis_hrq", 8'(hrq_o), 8'd0);
    settle(4'h0);

    // Polarity: active-low DREQ, active-high DACK
    cmd = 8'hC0; dreq = 4'b1110;
    repeat (5) step();
    check("pol_pending", 8'(pending_req_o), 8'b0001);
    wait_hrq(10);
    hlda = 1'b1;
    step();
    check("pol_dack", 8'(dack_o), 8'b0001);
    sd = 1'b1; step(); sd = 1'b0; hlda = 1'b0;
    settle(4'hF);

    // Withdraw before HLDA
    cmd = 8'h00; dreq = 4'b0100;
    wait_hrq(10);
    dreq = 4'h0;
    repeat (3) step();
    check("wd_pending", 8'(pending_req_o), 8'd0);
    check("wd_hrq_still", 8'(hrq_o), 8'd1);
    step();
    check("wd_hrq_low", 8'(hrq_o), 8'd0);
    settle(4'h0);

    // Abort by HLDA drop: pointer must not move
    cmd = 8'h10; dreq = 4'b0010;
    serve();
    check("abort_pre_chan", 8'(last_chan), 8'd1);
    dreq = 4'b1111;
    repeat (4) step();
    exp_ch = ROT_EN ? 2'd2 : 2'd0;
    wait_hrq(10);
    hlda = 1'b1;
    step();
    check("abort_chan", 8'(grant_chan_o), 8'(exp_ch));
    hlda = 1'b0;
    step();
    check("abort_gv", 8'(grant_valid_o), 8'd0);
    check("abort_hrq", 8'(hrq_o), 8'd0);
    check("abort_dack", 8'(dack_o), 8'h0F);
    wait_hrq(10);
    hlda = 1'b1;
    step();
    check("abort_chan_kept", 8'(grant_chan_o), 8'(exp_ch));
    sd = 1'b1; step(); sd = 1'b0; hlda = 1'b0;
    settle(4'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 50 == 0)
        cmd = {1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom % 8 == 0), 2'b00};
      if ($urandom % 4 == 0) dreq = 4'($urandom);
      if ($urandom % 40 == 0) mask = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      if (hrq_o && !hlda) hlda = ($urandom % 3 == 0);
      else if (hlda && !hrq_o) hlda = ($urandom % 2 == 0) ? 1'b0 : 1'b1;
      else if (hlda && grant_valid_o && $urandom % 40 == 0) hlda = 1'b0;
      sd = !sd && ((grant_valid_o && $urandom % 4 == 0) || $urandom % 30 == 0);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      step();
    end

    chk_en = 1'b0;
    step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
